// File: rtl/nt_neurotransmitter_channel.sv
// Parametrised neurotransmitter level channel: regulator-driven value register with
// reuptake decay toward a baseline and a hysteretic quantised level output.
module nt_neurotransmitter_channel #(
  parameter int unsigned N            = 6,
  parameter int unsigned OUT_W        = 2,
  parameter int unsigned SET_VAL      = 32,
  parameter int unsigned DEFAULT_VAL  = 0,
  parameter int unsigned FAST_STEP    = 3,
  parameter int unsigned BASELINE     = 0,
  parameter int unsigned DECAY_PERIOD = 16,
  parameter int unsigned HYST         = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             fast,
  input  logic             setval,
  input  logic             decay_en,
  output logic [N-1:0]     value,
  output logic [OUT_W-1:0] level,
  output logic             at_max,
  output logic             at_min
);

  localparam int unsigned CW = $clog2(DECAY_PERIOD + 1);
  localparam int unsigned SH = N - OUT_W;

  localparam logic [N:0]       MAX_EXT   = {1'b0, {N{1'b1}}};
  localparam logic [N:0]       FAST_EXT  = (N+1)'(FAST_STEP);
  localparam logic [N:0]       ONE_EXT   = (N+1)'(1);
  localparam logic [N:0]       HYST_EXT  = (N+1)'(HYST);
  localparam logic [N-1:0]     ONE       = N'(1);
  localparam logic [N-1:0]     SET_V     = N'(SET_VAL);
  localparam logic [N-1:0]     DEF_V     = N'(DEFAULT_VAL);
  localparam logic [N-1:0]     BASE_V    = N'(BASELINE);
  localparam logic [OUT_W-1:0] DEF_LVL   = OUT_W'(DEFAULT_VAL >> SH);
  localparam logic [CW-1:0]    LAST_CNT  = CW'(DECAY_PERIOD - 1);

  logic [N-1:0]     value_q, value_d;
  logic [OUT_W-1:0] level_q, level_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [N:0]       step, sum_ext, hyst_sum, lvl_floor;
  logic [OUT_W-1:0] tgt;
  logic             activity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= DEF_V;
      level_q <= DEF_LVL;
      cnt_q   <= '0;
    end else begin
      value_q <= value_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    activity = setval | inc | dec;
    step     = fast ? FAST_EXT : ONE_EXT;
    sum_ext  = {1'b0, value_q} + step;
    value_d  = value_q;
    cnt_d    = cnt_q;

    if (setval) begin
      value_d = SET_V;
    end else if (inc && !dec) begin
      value_d = (sum_ext > MAX_EXT) ? MAX_EXT[N-1:0] : sum_ext[N-1:0];
    end else if (dec && !inc) begin
      value_d = ({1'b0, value_q} < step) ? '0 : value_q - step[N-1:0];
    end

    // Decay only acts on idle cycles; the counter is cleared by any activity.
    if (activity) begin
      cnt_d = '0;
    end else if (decay_en) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d = '0;
        if (value_q < BASE_V)      value_d = value_q + ONE;
        else if (value_q > BASE_V) value_d = value_q - ONE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    tgt       = OUT_W'(value_q >> SH);
    hyst_sum  = {1'b0, value_q} + HYST_EXT;
    lvl_floor = (N+1)'(level_q) << SH;
    level_d   = level_q;
    // Rising is immediate; falling needs value to clear the level floor by HYST.
    if (tgt > level_q) begin
      level_d = tgt;
    end else if ((tgt < level_q) && (hyst_sum < lvl_floor)) begin
      level_d = tgt;
    end
  end

  assign value  = value_q;
  assign level  = level_q;
  assign at_max = &value_q;
  assign at_min = ~|value_q;

endmodule
